instr_encoder: RTL and testbench

- Inverse of the main opcode decoder: accepts instruction fields tagged with an instruction kind and packs them into 32-bit MIPS words.
- Encoded words are buffered in a small FIFO and streamed out with sequential word addresses, for preloading instruction memory from a testbench or boot loader.
- Supported opcodes: R-type, j, jal, lw, sw, beq, bne, ori, lui.

---
 rtl/instr_encoder_if.sv | 31 +++
 rtl/instr_encoder.sv | 162 ++++++++++++++++
 tb/tb_instr_encoder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the instruction encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
        output out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
        input  out_ready,
        output in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs tagged instruction fields into MIPS words and streams them through a FIFO with byte addresses.
// Optional macro INSTR_ENCODER_BRANCH_ABS_EN: BEQ/BNE take an absolute target and compute the offset.
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    instr_encoder_if.slave   bus,
    output logic             err_illegal,
    output logic             err_range
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    localparam logic [3:0] K_R   = 4'd0;
    localparam logic [3:0] K_J   = 4'd1;
    localparam logic [3:0] K_JAL = 4'd2;
    localparam logic [3:0] K_LW  = 4'd3;
    localparam logic [3:0] K_SW  = 4'd4;
    localparam logic [3:0] K_BEQ = 4'd5;
    localparam logic [3:0] K_BNE = 4'd6;
    localparam logic [3:0] K_ORI = 4'd7;
    localparam logic [3:0] K_LUI = 4'd8;

    function automatic logic [31:0] f_encode(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        case (kind)
            K_R:     word = {6'b000000, rs, rt, rd, shamt, funct};
            K_J:     word = {6'b000010, target};
            K_JAL:   word = {6'b000011, target};
            K_LW:    word = {6'b100011, rs, rt, imm};
            K_SW:    word = {6'b101011, rs, rt, imm};
            K_BEQ:   word = {6'b000100, rs, rt, imm};
            K_BNE:   word = {6'b000101, rs, rt, imm};
            K_ORI:   word = {6'b001101, rs, rt, imm};
            K_LUI:   word = {6'b001111, 5'b00000, rt, imm};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    logic [31:0]       r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_enq_addr;
    logic              r_err_illegal;
    logic              r_err_range;

    logic              w_accept;
    logic              w_kind_ok;
    logic              w_range_bad;
    logic              w_push;
    logic              w_pop;
    logic [15:0]       w_imm;
    logic [31:0]       w_word;

`ifdef INSTR_ENCODER_BRANCH_ABS_EN
    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] w_off;
    logic              w_is_br;

    // Branch offset from the absolute target, relative to the delay-slot address.
    always_comb begin
        w_tgt   = ADDR_W'(bus.in_target);
        w_off   = w_tgt - (r_enq_addr + ADDR_STEP);
        w_is_br = (bus.in_kind == K_BEQ) || (bus.in_kind == K_BNE);
        if (w_is_br) begin
            w_imm       = w_off[17:2];
            w_range_bad = (w_off[1:0] != 2'b00) ||
                          !((&w_off[ADDR_W-1:17]) || (~|w_off[ADDR_W-1:17]));
        end else begin
            w_imm       = bus.in_imm;
            w_range_bad = 1'b0;
        end
    end
`else
    // Immediate taken verbatim; no range errors are possible.
    always_comb begin
        w_imm       = bus.in_imm;
        w_range_bad = 1'b0;
    end
`endif

    // Handshake qualification and word formation.
    always_comb begin
        w_kind_ok = (bus.in_kind <= K_LUI);
        w_accept  = bus.in_valid && (r_count != CNT_FULL);
        w_push    = w_accept && w_kind_ok && !w_range_bad;
        w_pop     = (r_count != {CNT_W{1'b0}}) && bus.out_ready;
        w_word    = f_encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt,
                             bus.in_funct, w_imm, bus.in_target);
    end

    // FIFO storage, pointers, enqueue address and sticky error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= 32'h0000_0000;
                r_mem_addr[i] <= BASE_ADDR;
            end
            r_wr_ptr      <= {PTR_W{1'b0}};
            r_rd_ptr      <= {PTR_W{1'b0}};
            r_count       <= {CNT_W{1'b0}};
            r_enq_addr    <= BASE_ADDR;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else if (clear) begin
            r_wr_ptr      <= {PTR_W{1'b0}};
            r_rd_ptr      <= {PTR_W{1'b0}};
            r_count       <= {CNT_W{1'b0}};
            r_enq_addr    <= BASE_ADDR;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_word;
                r_mem_addr[r_wr_ptr] <= r_enq_addr;
                r_wr_ptr             <= r_wr_ptr + PTR_ONE;
                r_enq_addr           <= r_enq_addr + ADDR_STEP;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_accept && !w_kind_ok) begin
                r_err_illegal <= 1'b1;
            end
            if (w_accept && w_kind_ok && w_range_bad) begin
                r_err_range <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = (r_count != CNT_FULL);
    assign bus.out_valid = (r_count != {CNT_W{1'b0}});
    assign bus.out_data  = r_mem_data[r_rd_ptr];
    assign bus.out_addr  = r_mem_addr[r_rd_ptr];
    assign err_illegal   = r_err_illegal;
    assign err_range     = r_err_range;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: queue-based reference model checked every cycle, plus literal checks.
module tb_instr_encoder;
    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic err_illegal;
    logic err_range;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .err_illegal(err_illegal), .err_range(err_range)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] m_q[$];
    logic [63:0] m_log[$];
    logic [31:0] m_addr;
    bit          m_ill;
    bit          m_rng;

    function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference encoding from the opcode table using plain arithmetic.
    function automatic logic [31:0] model_word(input int kind, input int rs, input int rt,
                                               input int rd, input int sh, input int fn,
                                               input int imm, input int tg, input int addr,
                                               output bit rng);
        int op;
        int diff;
        rng = 0;
        case (kind)
            0: op = 0;   1: op = 2;   2: op = 3;   3: op = 35;  4: op = 43;
            5: op = 4;   6: op = 5;   7: op = 13;  default: op = 15;
        endcase
`ifdef INSTR_ENCODER_BRANCH_ABS_EN
        if (kind == 5 || kind == 6) begin
            diff = tg - (addr + 4);
            if ((diff % 4) != 0 || (diff / 4) > 32767 || (diff / 4) < -32768) rng = 1;
            imm = (diff / 4) & 32'hFFFF;
        end
`else
        diff = addr;
`endif
        if (kind == 0) return 32'(op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn);
        if (kind == 1 || kind == 2) return 32'(op * 67108864 + tg);
        if (kind == 8) return 32'(op * 67108864 + rt * 65536 + imm);
        return 32'(op * 67108864 + rs * 2097152 + rt * 65536 + imm);
    endfunction

    // Reference model: transfer and pop decisions from its own occupancy.
    always @(posedge clk or negedge rst_n) begin
        bit          acc;
        bit          pop;
        bit          rng;
        logic [31:0] w;
        if (!rst_n || clear) begin
            m_q.delete();
            m_addr = BASE;
            m_ill  = 0;
            m_rng  = 0;
        end else begin
            acc = bus.in_valid && (m_q.size() < DEPTH);
            pop = (m_q.size() > 0) && bus.out_ready;
            if (pop) m_log.push_back(m_q.pop_front());
            if (acc) begin
                if (bus.in_kind > 4'd8) begin
                    m_ill = 1;
                end else begin
                    w = model_word(int'(bus.in_kind), int'(bus.in_rs), int'(bus.in_rt), int'(bus.in_rd),
                                   int'(bus.in_shamt), int'(bus.in_funct), int'(bus.in_imm),
                                   int'(bus.in_target), int'(m_addr), rng);
                    if (rng) begin
                        m_rng = 1;
                    end else begin
                        m_q.push_back({m_addr, w});
                        m_addr = m_addr + 32'd4;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        logic [63:0] h;
        if (rst_n) begin
            check("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
            check("in_ready", 64'(bus.in_ready), 64'(m_q.size() != DEPTH));
            check("err_illegal", 64'(err_illegal), 64'(m_ill));
            check("err_range", 64'(err_range), 64'(m_rng));
            if (m_q.size() != 0) begin
                h = m_q[0];
                check("out_data", 64'(bus.out_data), 64'(h[31:0]));
                check("out_addr", 64'(bus.out_addr), 64'(h[63:32]));
            end
        end
    end

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tg);
        bit ok;
        bus.in_kind = k;  bus.in_rs = rs;  bus.in_rt = rt;  bus.in_rd = rd;
        bus.in_shamt = sh; bus.in_funct = fn; bus.in_imm = imm; bus.in_target = tg;
        bus.in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: kind %0d never accepted, required acceptance", k);
        end
    endtask

    task automatic ori(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        send(4'd7, rs, rt, 5'd0, 5'd0, 6'd0, imm, 26'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 100 && m_q.size() != 0; i++) idle(1);
        idle(1);
        if (m_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d words left, required 0", m_q.size());
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < m_log.size()) begin
            check(name, m_log[idx], {a, d});
        end else begin
            check(name, 64'hDEAD_DEAD_DEAD_DEAD, {a, d});
        end
    endtask

    int base;

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_kind = 4'd0;
        bus.in_rs = 5'd0; bus.in_rt = 5'd0; bus.in_rd = 5'd0; bus.in_shamt = 5'd0;
        bus.in_funct = 6'd0; bus.in_imm = 16'd0; bus.in_target = 26'd0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_addr", 64'(bus.out_addr), 64'(BASE));

        // single ORI, visible the cycle after the push
        bus.out_ready = 1'b1;
        ori(5'd1, 5'd2, 16'h00FF);
        check("ori_valid", 64'(bus.out_valid), 64'd1);
        check("ori_data", 64'(bus.out_data), 64'h3422_00FF);
        check("ori_addr", 64'(bus.out_addr), 64'h0);
        idle(2);

        // back-to-back mixed kinds
        do_clear();
        base = m_log.size();
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
        send(4'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
        send(4'd3, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
        send(4'd8, 5'd7, 5'd5, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
        wait_drain();
        chk_log("b2b_r",   base + 0, 32'h0, 32'h0022_1820);
        chk_log("b2b_j",   base + 1, 32'h4, 32'h0800_0010);
        chk_log("b2b_lw",  base + 2, 32'h8, 32'h8FA8_0004);
        chk_log("b2b_lui", base + 3, 32'hC, 32'h3C05_1234);

        // backpressure: fill, stall the 5th, then drain
        do_clear();
        bus.out_ready = 1'b0;
        base = m_log.size();
        for (int i = 1; i <= 4; i++) ori(5'(i), 5'(i), 16'(i));
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join_none
        ori(5'd5, 5'd5, 16'd5);
        wait_drain();
        chk_log("bp0", base + 0, 32'h00, 32'h3421_0001);
        chk_log("bp1", base + 1, 32'h04, 32'h3442_0002);
        chk_log("bp2", base + 2, 32'h08, 32'h3463_0003);
        chk_log("bp3", base + 3, 32'h0C, 32'h3484_0004);
        chk_log("bp4", base + 4, 32'h10, 32'h34A5_0005);

        // illegal kind between two ORIs, then clear
        do_clear();
        base = m_log.size();
        ori(5'd1, 5'd2, 16'h0011);
        send(4'd12, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1);
        check("ill_set", 64'(err_illegal), 64'd1);
        ori(5'd3, 5'd4, 16'h0022);
        wait_drain();
        check("ill_sticky", 64'(err_illegal), 64'd1);
        chk_log("ill_a", base + 0, 32'h0, 32'h3422_0011);
        chk_log("ill_b", base + 1, 32'h4, 32'h3464_0022);
        do_clear();
        check("ill_clr", 64'(err_illegal), 64'd0);
        ori(5'd1, 5'd2, 16'h0033);
        wait_drain();
        chk_log("ill_after_clr", base + 2, 32'h0, 32'h3422_0033);

`ifdef INSTR_ENCODER_BRANCH_ABS_EN
        do_clear();
        base = m_log.size();
        ori(5'd1, 5'd1, 16'd1);
        ori(5'd1, 5'd1, 16'd2);
        send(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 26'h4);
        wait_drain();
        chk_log("beq_abs", base + 2, 32'h8, 32'h1022_FFFE);
        send(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 26'h6);
        idle(1);
        check("rng_set", 64'(err_range), 64'd1);
        check("rng_no_word", 64'(bus.out_valid), 64'd0);
        ori(5'd1, 5'd2, 16'h0044);
        wait_drain();
        chk_log("rng_next_addr", base + 3, 32'hC, 32'h3422_0044);
`endif

        // async reset with buffered words
        do_clear();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) ori(5'd1, 5'd2, 16'(i));
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        idle(1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(1);
        base = m_log.size();
        ori(5'd5, 5'd6, 16'h0007);
        wait_drain();
        chk_log("rst_first_addr", base + 0, BASE, 32'h34A6_0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
